modulation_segment_gen: RTL

Bit-to-symbol modulator for the modulation pipe: accepts a 32-bit data word on a start handshake and serialises it into Q16.16 segment samples. Each bit expands to `SEGMENTS` samples of the fixed ±1.0 reference chip pattern, or its negation. It is the transmit-side counterpart of the segment demodulator: a bit of 1 produces `ref[k]` and a bit of 0 produces `ref_m[k]`, so the demodulator's zero-threshold decision recovers the word.

---
 rtl/mod_pkg.sv | 25 ++
 rtl/mod_ref_rom.sv | 28 ++
 rtl/modulation_segment_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// mod_pkg: shared constants and types for the modulation segment generator.
//   Q_ONE / Q_MINUS_ONE : Q16.16 reference chip levels (+1.0 / -1.0)
//   DEFAULT_SEGMENTS    : samples per bit
//   DEFAULT_NUM_BITS    : bits serialised per word
//   modState_e          : generator FSM states
//   qNegate             : two's complement negation of a Q16.16 value
package mod_pkg;

  localparam logic [31:0] Q_ONE       = 32'h0001_0000;
  localparam logic [31:0] Q_MINUS_ONE = 32'hFFFF_0000;

  localparam int DEFAULT_SEGMENTS = 10;
  localparam int DEFAULT_NUM_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } modState_e;

  function automatic logic [31:0] qNegate(input logic [31:0] value);
    return ~value + 32'd1;
  endfunction

endpackage

// File: rtl/mod_ref_rom.sv
// mod_ref_rom: reference chip pattern lookup.
// Maps a segment index k to ref[k]: +1.0 for even k, -1.0 for odd k.
// Indices at or beyond SEGMENTS return zero so an out-of-range index can
// never masquerade as a valid chip.
// Ports:
//   segIdx_i     in  4   segment index k
//   refSample_o  out 32  Q16.16 reference sample ref[k]
module mod_ref_rom
  import mod_pkg::*;
#(
  parameter int SEGMENTS = DEFAULT_SEGMENTS
) (
  input  logic [3:0]  segIdx_i,
  output logic [31:0] refSample_o
);

  localparam logic [3:0] LAST_SEG = 4'(SEGMENTS - 1);

  // Alternating +1/-1 chip; swapping this block is how another chip
  // pattern would be introduced without touching the generator.
  always_comb begin
    refSample_o = '0;
    if (segIdx_i <= LAST_SEG) begin
      refSample_o = segIdx_i[0] ? Q_MINUS_ONE : Q_ONE;
    end
  end

endmodule

// File: rtl/modulation_segment_gen.sv
// modulation_segment_gen: bit-to-symbol modulator.
// Captures a 32-bit word on start and serialises it LSB first, emitting
// SEGMENTS Q16.16 samples per bit: ref[k] for a 1 bit, -ref[k] for a 0 bit.
// Optional feature macro: MOD_BACKPRESSURE_EN adds the ready input; while
// valid is high and ready is low, the current sample and counters hold.
// Ports:
//   clk          in  1   clock, rising edge
//   reset        in  1   asynchronous active-high reset
//   ready        in  1   downstream accepts sample (MOD_BACKPRESSURE_EN only)
//   start        in  1   begin a word; honoured only while busy is low
//   input_bit    in  32  data word, captured on the accepted start
//   sample_out   out 32  Q16.16 sample
//   segment_idx  out 4   segment index of the current sample
//   bit_idx      out 5   bit index of the current sample
//   valid        out 1   sample_out / indices are meaningful
//   last         out 1   final sample of the word
//   busy         out 1   a word is in progress (EMIT or DONE)
module modulation_segment_gen
  import mod_pkg::*;
#(
  parameter int SEGMENTS = DEFAULT_SEGMENTS,
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MOD_BACKPRESSURE_EN
  input  logic        ready,
`endif
  input  logic        start,
  input  logic [31:0] input_bit,
  output logic [31:0] sample_out,
  output logic [3:0]  segment_idx,
  output logic [4:0]  bit_idx,
  output logic        valid,
  output logic        last,
  output logic        busy
);

  localparam logic [3:0] LAST_SEG = 4'(SEGMENTS - 1);
  localparam logic [4:0] LAST_BIT = 5'(NUM_BITS - 1);

  modState_e   state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  segCnt_q, segCnt_d;
  logic [4:0]  bitCnt_q, bitCnt_d;

  logic [31:0] sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;

  logic        transfer;
  logic [31:0] refSample;

`ifdef MOD_BACKPRESSURE_EN
  assign transfer = valid_q & ready;
`else
  assign transfer = valid_q;
`endif

  // The ROM looks at the next segment index so the registered sample
  // lines up with the registered indices in the same cycle.
  mod_ref_rom #(
    .SEGMENTS(SEGMENTS)
  ) uRefRom (
    .segIdx_i   (segCnt_d),
    .refSample_o(refSample)
  );

  // State register: FSM state, captured word and the two counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      segCnt_q <= '0;
      bitCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      segCnt_q <= segCnt_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  // Next-state logic. Counters only move on a transfer, so a stall freezes
  // them; leaving EMIT zeroes them so the index outputs read 0 when idle.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    segCnt_d = segCnt_q;
    bitCnt_d = bitCnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d   = input_bit;
          segCnt_d = '0;
          bitCnt_d = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (transfer) begin
          if (segCnt_q == LAST_SEG) begin
            segCnt_d = '0;
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_d = '0;
              state_d  = DONE;
            end else begin
              bitCnt_d = bitCnt_q + 5'd1;
            end
          end else begin
            segCnt_d = segCnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  // A 0 bit selects the negated chip.
  always_comb begin
    sample_d = '0;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    if (state_d == EMIT) begin
      valid_d  = 1'b1;
      sample_d = word_d[bitCnt_d] ? refSample : qNegate(refSample);
      last_d   = (segCnt_d == LAST_SEG) && (bitCnt_d == LAST_BIT);
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  assign sample_out  = sample_q;
  assign segment_idx = segCnt_q;
  assign bit_idx     = bitCnt_q;
  assign valid       = valid_q;
  assign last        = last_q;
  assign busy        = busy_q;

endmodule
